rv_ifetch_buf: RTL

Instruction fetch buffer that sits directly upstream of the pipeline's IF/ID register. It owns the fetch PC and issues sequential word fetches to an instruction memory with a valid/ready request channel and an in-order, variable-latency response channel. It queues returned instructions with their PCs in a small FIFO and presents them to the decode stage under valid/ready. A redirect (taken branch or exception target) flushes the FIFO and discards stale in-flight responses.

---
 rtl/rv_ifetch_buf.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rv_ifetch_buf.sv
// rv_ifetch_buf
// Instruction fetch buffer feeding the IF/ID register. It owns the fetch PC
// and issues sequential word fetches over a valid/ready request channel. The
// memory answers in request order with variable latency. Returned words are
// queued with their PCs in a small FIFO and handed to decode under
// valid/ready. A redirect flushes the FIFO, restarts fetch at the new target
// and marks every in-flight response as stale so that it is discarded.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address (bits [1:0] ignored)
//   mem_req_valid   fetch request valid
//   mem_req_addr    fetch address, always word aligned
//   mem_req_ready   memory accepts the request
//   mem_rsp_valid   instruction word returned (in order, always accepted)
//   mem_rsp_data    returned instruction word
//   out_valid       FIFO head valid
//   out_pc          PC of the head instruction
//   out_instr       head instruction word
//   out_ready       decode consumes the head
module rv_ifetch_buf #(
  parameter int unsigned   DW       = 32'd64,
  parameter int unsigned   DEPTH    = 32'd4,
  parameter logic [DW-1:0] RESET_PC = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [DW-1:0] redirect_pc,
  output logic          mem_req_valid,
  output logic [DW-1:0] mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_rsp_valid,
  input  logic [31:0]   mem_rsp_data,
  output logic          out_valid,
  output logic [DW-1:0] out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 32'd1;

  localparam logic [CW:0]   DEPTH_X = (CW + 32'd1)'(DEPTH);
  localparam logic [DW-1:0] PC_STEP = DW'(3'd4);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  // Architectural state
  logic [DW-1:0] fetch_pc_r;
  logic [DW-1:0] rsp_pc_r;
  logic [DW-1:0] pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] drop_cnt_r;

  // Next-state and handshake terms
  logic          credit_ok_s;
  logic          req_fire_s;
  logic          drop_now_s;
  logic          push_s;
  logic          pop_s;
  logic [DW-1:0] target_pc_s;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] outst_nxt_s;
  logic [CW-1:0] drop_nxt_s;
  logic [AW-1:0] wr_ptr_nxt_s;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic          unused_s;

  // The low two redirect bits carry no information for word fetches.
  assign unused_s = ^redirect_pc[1:0];

  // Outputs come straight from registers or the FIFO storage, never from mem_rsp.
  assign mem_req_addr = fetch_pc_r;
  assign out_valid    = (count_r != CNT_ZERO);
  assign out_pc       = pc_mem_r[rd_ptr_r];
  assign out_instr    = instr_mem_r[rd_ptr_r];

  // Request issue, FIFO push/pop decisions and counter next-state.
  always_comb begin
    target_pc_s = {redirect_pc[DW-1:2], 2'b00};
    // Widen by one bit so the credit sum can never wrap.
    credit_ok_s = (({1'b0, count_r} + {1'b0, outst_r}) < DEPTH_X);
    // rst_n gates the request so nothing is offered while reset is held.
    mem_req_valid = rst_n & credit_ok_s & ~redirect_valid;
    req_fire_s    = mem_req_valid & mem_req_ready;
    drop_now_s    = mem_rsp_valid & (drop_cnt_r != CNT_ZERO);
    push_s        = mem_rsp_valid & ~drop_now_s & ~redirect_valid;
    pop_s         = out_valid & out_ready & ~redirect_valid;

    // Every response still in flight holds credit until it returns.
    outst_nxt_s = outst_r + CW'(req_fire_s) - CW'(mem_rsp_valid);

    // On redirect every in-flight response becomes stale: the previously
    // stale ones plus the live ones, i.e. all of outstanding, minus the one
    // (if any) arriving and being discarded right now. Because outstanding
    // already includes earlier stale responses, back-to-back redirects do
    // not double count them.
    if (redirect_valid) begin
      drop_nxt_s = outst_r - CW'(mem_rsp_valid);
    end else if (drop_now_s) begin
      drop_nxt_s = drop_cnt_r - CW'(1'b1);
    end else begin
      drop_nxt_s = drop_cnt_r;
    end

    if (redirect_valid) begin
      count_nxt_s  = CNT_ZERO;
      wr_ptr_nxt_s = PTR_ZERO;
      rd_ptr_nxt_s = PTR_ZERO;
    end else begin
      count_nxt_s  = count_r + CW'(push_s) - CW'(pop_s);
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
    end
  end

  // PCs, counters and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      outst_r    <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
    end else begin
      if (redirect_valid) begin
        fetch_pc_r <= target_pc_s;
        rsp_pc_r   <= target_pc_s;
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (push_s) begin
          rsp_pc_r <= rsp_pc_r + PC_STEP;
        end
      end
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      outst_r    <= outst_nxt_s;
      drop_cnt_r <= drop_nxt_s;
    end
  end

  // FIFO storage: {pc, instr} written at the tail on every accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_r[i]    <= {DW{1'b0}};
        instr_mem_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= rsp_pc_r;
        instr_mem_r[wr_ptr_r] <= mem_rsp_data;
      end
    end
  end

endmodule
